// File: rtl/regfile_scan_checker_pkg.sv
// Shared types and default widths for the regfile scan checker.
// The state encoding lives here so top and bench agree on it.
package regfile_scan_checker_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 5;
    localparam int DEF_NUM_REGS    = 32;
    localparam int DEF_CYCLE_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_scan_checker_compare.sv
// Second pipeline stage of the scan: registers the regfile read with its index,
// compares it against the ROM word that arrives one cycle later, and tallies failures.
module scan_compare_stage
    import regfile_scan_checker_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_issue,
    input  logic [ADDR_WIDTH-1:0] i_idx,
    input  logic [DATA_WIDTH-1:0] i_actData,
    input  logic [DATA_WIDTH-1:0] i_expData,
    input  logic                  i_expValid,
    output logic                  o_mismatchValid,
    output logic [ADDR_WIDTH-1:0] o_mismatchReg,
    output logic [ADDR_WIDTH:0]   o_errorCount,
    output logic [ADDR_WIDTH-1:0] o_firstFailReg,
    output logic [DATA_WIDTH-1:0] o_firstFailExp,
    output logic [DATA_WIDTH-1:0] o_firstFailAct
);

    localparam logic [ADDR_WIDTH:0] ERR_ONE = (ADDR_WIDTH + 1)'(1);

    logic                  r_stageValid;
    logic [ADDR_WIDTH-1:0] r_stageIdx;
    logic [DATA_WIDTH-1:0] r_stageAct;
    logic                  r_mismatchValid;
    logic [ADDR_WIDTH-1:0] r_mismatchReg;
    logic [ADDR_WIDTH:0]   r_errorCount;
    logic [ADDR_WIDTH-1:0] r_firstFailReg;
    logic [DATA_WIDTH-1:0] r_firstFailExp;
    logic [DATA_WIDTH-1:0] r_firstFailAct;
    logic                  w_mismatch;

    // exp_data/exp_valid belong to the index issued last cycle, i.e. to r_stageIdx.
    assign w_mismatch = r_stageValid && i_expValid && (r_stageAct != i_expData);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stageValid    <= 1'b0;
            r_stageIdx      <= '0;
            r_stageAct      <= '0;
            r_mismatchValid <= 1'b0;
            r_mismatchReg   <= '0;
            r_errorCount    <= '0;
            r_firstFailReg  <= '0;
            r_firstFailExp  <= '0;
            r_firstFailAct  <= '0;
        end else begin
            r_stageValid    <= i_issue;
            r_stageIdx      <= i_idx;
            r_stageAct      <= i_actData;
            r_mismatchValid <= 1'b0;
            if (i_clear) begin
                r_errorCount   <= '0;
                r_firstFailReg <= '0;
                r_firstFailExp <= '0;
                r_firstFailAct <= '0;
            end else if (w_mismatch) begin
                r_mismatchValid <= 1'b1;
                r_mismatchReg   <= r_stageIdx;
                r_errorCount    <= r_errorCount + ERR_ONE;
                if (r_errorCount == '0) begin
                    r_firstFailReg <= r_stageIdx;
                    r_firstFailExp <= i_expData;
                    r_firstFailAct <= r_stageAct;
                end
            end
        end
    end

    assign o_mismatchValid = r_mismatchValid;
    assign o_mismatchReg   = r_mismatchReg;
    assign o_errorCount    = r_errorCount;
    assign o_firstFailReg  = r_firstFailReg;
    assign o_firstFailExp  = r_firstFailExp;
    assign o_firstFailAct  = r_firstFailAct;

endmodule

// File: rtl/regfile_scan_checker.sv
// Bring-up self-check: run the CPU for num_cycles, then borrow regfile read port A
// and walk every register against an expected-value ROM.
module regfile_scan_checker
    import regfile_scan_checker_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int CYCLE_WIDTH = DEF_CYCLE_WIDTH
)
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CYCLE_WIDTH-1:0] num_cycles,
    output logic                   test_mode,
    output logic [ADDR_WIDTH-1:0]  scan_addr,
    input  logic [DATA_WIDTH-1:0]  reg_data,
    output logic [ADDR_WIDTH-1:0]  exp_addr,
    input  logic [DATA_WIDTH-1:0]  exp_data,
    input  logic                   exp_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ADDR_WIDTH:0]    error_count,
    output logic                   mismatch_valid,
    output logic [ADDR_WIDTH-1:0]  mismatch_reg,
    output logic [ADDR_WIDTH-1:0]  first_fail_reg,
    output logic [DATA_WIDTH-1:0]  first_fail_exp,
    output logic [DATA_WIDTH-1:0]  first_fail_act,
    output logic [CYCLE_WIDTH-1:0] cycle_count
);

    localparam logic [ADDR_WIDTH-1:0]  LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0]  IDX_ONE   = ADDR_WIDTH'(1);
    localparam logic [CYCLE_WIDTH-1:0] CYCLE_ONE = CYCLE_WIDTH'(1);
    localparam logic [CYCLE_WIDTH-1:0] CYCLE_MAX = '1;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [CYCLE_WIDTH-1:0] r_numCycles;
    logic [CYCLE_WIDTH-1:0] r_cycleCount;
    logic [ADDR_WIDTH-1:0]  r_idx;
    logic                   w_start;
    logic                   w_issue;
    logic                   w_runLast;
    logic [ADDR_WIDTH:0]    w_errorCount;

    assign w_start   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_issue   = (r_state == ST_SCAN);
    assign w_runLast = (r_cycleCount == (r_numCycles - CYCLE_ONE));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_nextState = (num_cycles == '0) ? ST_SCAN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_runLast) begin
                    w_nextState = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_idx == LAST_IDX) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: w_nextState = ST_DONE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_numCycles  <= '0;
            r_cycleCount <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_start) begin
                r_numCycles  <= num_cycles;
                r_cycleCount <= '0;
            end else if ((r_state == ST_RUN) && (r_cycleCount != CYCLE_MAX)) begin
                r_cycleCount <= r_cycleCount + CYCLE_ONE;
            end
        end
    end

    // The index holds at the last register through DRAIN so the final read stays stable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (w_start) begin
            r_idx <= '0;
        end else if ((r_state == ST_SCAN) && (r_idx != LAST_IDX)) begin
            r_idx <= r_idx + IDX_ONE;
        end else if (r_state == ST_DRAIN) begin
            r_idx <= '0;
        end
    end

    scan_compare_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_compare (
        .clock           (clock),
        .reset           (reset),
        .i_clear         (w_start),
        .i_issue         (w_issue),
        .i_idx           (r_idx),
        .i_actData       (reg_data),
        .i_expData       (exp_data),
        .i_expValid      (exp_valid),
        .o_mismatchValid (mismatch_valid),
        .o_mismatchReg   (mismatch_reg),
        .o_errorCount    (w_errorCount),
        .o_firstFailReg  (first_fail_reg),
        .o_firstFailExp  (first_fail_exp),
        .o_firstFailAct  (first_fail_act)
    );

    assign test_mode   = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
    assign scan_addr   = r_idx;
    assign exp_addr    = r_idx;
    assign busy        = (r_state == ST_RUN) || test_mode;
    assign done        = (r_state == ST_DONE);
    assign pass        = done && (w_errorCount == '0);
    assign error_count = w_errorCount;
    assign cycle_count = r_cycleCount;

endmodule

// File: doc/regfile_scan_checker.md
Name: regfile_scan_checker

Overview:
Hardware self-check engine for processor bring-up.
- Runs the CPU for a programmable number of cycles.
- Then takes over one regfile read port and scans every register in order.
- Compares each register against an expected-value ROM, counting mismatches and capturing the first failure.
- Sits between the processor, the regfile read-port-A mux and an expected-value ROM, so on-board runs self-check without a simulator harness.

Parameters:
- DATA_WIDTH, 32, register/expected data width
- ADDR_WIDTH, 5, register index width
- NUM_REGS, 32, registers scanned (indices 0..NUM_REGS-1); NUM_REGS <= 2**ADDR_WIDTH
- CYCLE_WIDTH, 16, run-cycle counter width

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- start  in  1  single-cycle start pulse
- num_cycles  in  CYCLE_WIDTH  run length, sampled on accepted start
- test_mode  out  1  1 = regfile read port A driven by scan_addr
- scan_addr  out  ADDR_WIDTH  regfile read address during scan
- reg_data  in  DATA_WIDTH  regfile read data, combinational from scan_addr
- exp_addr  out  ADDR_WIDTH  expected-ROM address
- exp_data  in  DATA_WIDTH  expected value, valid 1 cycle after exp_addr
- exp_valid  in  1  qualifies exp_data, same timing; 0 = register not checked
- busy  out  1  RUN, SCAN or DRAIN
- done  out  1  check complete, held
- pass  out  1  done and error_count == 0
- error_count  out  ADDR_WIDTH+1  mismatch count
- mismatch_valid  out  1  one-cycle pulse per mismatch
- mismatch_reg  out  ADDR_WIDTH  index of mismatching register
- first_fail_reg  out  ADDR_WIDTH  first mismatching index
- first_fail_exp  out  DATA_WIDTH  expected value at first mismatch
- first_fail_act  out  DATA_WIDTH  actual value at first mismatch
- cycle_count  out  CYCLE_WIDTH  cycles elapsed in RUN

Behaviour:
- Reset values: every output 0; state IDLE; all counters and capture registers cleared.
- Reset asserted mid-operation aborts immediately to IDLE; test_mode drops asynchronously.
- States are IDLE, RUN, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 latches num_cycles and clears error_count, first_fail_* and cycle_count.
  - Next state is RUN, or SCAN if num_cycles == 0.
- RUN:
  - cycle_count increments each clock.
  - When cycle_count == num_cycles-1 on an edge, go to SCAN. Exactly num_cycles cycles are spent in RUN.
- SCAN:
  - test_mode=1.
  - idx starts at 0; scan_addr = exp_addr = idx; idx increments every cycle.
  - reg_data is registered with idx; the compare happens the following cycle, aligned with exp_data/exp_valid.
  - After idx == NUM_REGS-1 is issued, go to DRAIN.
- DRAIN:
  - One cycle; completes the last compare.
  - test_mode stays 1 so the last address stays stable.
- Compare, at stage 2:
  - If exp_valid and the registered actual != exp_data, raise mismatch_valid for 1 cycle, set mismatch_reg and increment error_count.
  - If error_count was 0 before this increment, capture first_fail_reg/exp/act.
  - exp_valid=0 skips the register: no count, no pulse.
  - error_count cannot overflow (max NUM_REGS).
- DONE:
  - done=1, busy=0, test_mode=0, pass = (error_count == 0).
  - Results are held.
  - start=1 restarts exactly as from IDLE; done clears on that edge.
- start while busy is ignored.
- Latency:
  - start to the first SCAN cycle is num_cycles+1 clocks.
  - SCAN+DRAIN takes NUM_REGS+1 clocks.
  - done rises num_cycles+NUM_REGS+2 clocks after the start edge.
- cycle_count saturates at all-ones and does not wrap.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RUN, SCAN, DRAIN, DONE)
  - default widths DATA_WIDTH=32, ADDR_WIDTH=5, CYCLE_WIDTH=16
- One sub-module is natural: scan_compare_stage.
  - Contains the idx-to-compare pipeline register, mismatch detect, error counter and first-fail capture.
  - FSM and counters stay in the top module.

Test Plan:
- Regfile model r[i]=i*3, ROM identical, all exp_valid=1, num_cycles=10, start -> test_mode rises after 11 clocks, done at clock 44, error_count=0, pass=1, no mismatch_valid pulses.
- Same setup with ROM[7]=99 and ROM[20]=0 -> two mismatch_valid pulses with mismatch_reg 7 then 20, error_count=2, first_fail_reg=7, first_fail_exp=99, first_fail_act=21, pass=0.
- ROM[7]=99 but exp_valid=0 for index 7 -> error_count=0, pass=1.
- num_cycles=0 -> RUN skipped, SCAN starts the cycle after start; cycle_count=0; done after NUM_REGS+2 clocks.
- Reset driven low during SCAN at idx=12 -> all outputs 0 asynchronously, test_mode=0; a following start runs a full clean check.
- start pulsed during RUN is ignored (done timing unchanged); start in DONE with a new ROM mismatch at reg 3 -> done clears, rerun reports first_fail_reg=3, error_count=1.
